// File: rtl/beehive_port_steer.sv
// RX fork of one MAC AXIS stream to bypass + NUM_APPS engines (per-frame destination mask),
// and packet-atomic round-robin TX merge of the same ports back to the MAC.
module beehive_port_steer #(
  parameter int DATA_WIDTH    = 512,
  parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter int RX_USER_WIDTH = 1,
  parameter int TX_USER_WIDTH = 1,
  parameter int NUM_APPS      = 2,
  localparam int NP           = NUM_APPS + 1
) (
  input  logic                        clk,
  input  logic                        rst_n,

  input  logic [DATA_WIDTH-1:0]       s_rx_tdata,
  input  logic [KEEP_WIDTH-1:0]       s_rx_tkeep,
  input  logic                        s_rx_tvalid,
  input  logic                        s_rx_tlast,
  input  logic [RX_USER_WIDTH-1:0]    s_rx_tuser,
  output logic                        s_rx_tready,
  input  logic [NP-1:0]               s_rx_dest_mask,

  output logic [DATA_WIDTH-1:0]       m_rx_tdata,
  output logic [KEEP_WIDTH-1:0]       m_rx_tkeep,
  output logic                        m_rx_tlast,
  output logic [RX_USER_WIDTH-1:0]    m_rx_tuser,
  output logic [NP-1:0]               m_rx_tvalid,
  input  logic [NP-1:0]               m_rx_tready,

  input  logic [NP*DATA_WIDTH-1:0]    s_tx_tdata,
  input  logic [NP*KEEP_WIDTH-1:0]    s_tx_tkeep,
  input  logic [NP-1:0]               s_tx_tlast,
  input  logic [NP*TX_USER_WIDTH-1:0] s_tx_tuser,
  input  logic [NP-1:0]               s_tx_tvalid,
  output logic [NP-1:0]               s_tx_tready,

  output logic [DATA_WIDTH-1:0]       m_tx_tdata,
  output logic [KEEP_WIDTH-1:0]       m_tx_tkeep,
  output logic                        m_tx_tvalid,
  output logic                        m_tx_tlast,
  output logic [TX_USER_WIDTH-1:0]    m_tx_tuser,
  input  logic                        m_tx_tready,

  output logic [31:0]                 rx_drop_cnt
);

  localparam int GW = (NP > 1) ? $clog2(NP) : 1;
  localparam int SW = GW + 1;

  // ---------------- RX fork ----------------
  logic          sof;
  logic [NP-1:0] mask_q;
  logic [NP-1:0] done;
  logic [NP-1:0] mask_eff;
  logic          rx_hs;

  assign m_rx_tdata = s_rx_tdata;
  assign m_rx_tkeep = s_rx_tkeep;
  assign m_rx_tlast = s_rx_tlast;
  assign m_rx_tuser = s_rx_tuser;

  // Handshake gating with rst_n keeps every valid/ready low while reset is held.
  always_comb begin
    mask_eff    = sof ? s_rx_dest_mask : mask_q;
    m_rx_tvalid = {NP{s_rx_tvalid & rst_n}} & mask_eff & ~done;
    s_rx_tready = rst_n & (&(~mask_eff | done | m_rx_tready));
  end

  assign rx_hs = s_rx_tvalid & s_rx_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sof         <= 1'b1;
      mask_q      <= '0;
      done        <= '0;
      rx_drop_cnt <= '0;
    end else if (rx_hs) begin
      done   <= '0;
      sof    <= s_rx_tlast;
      mask_q <= mask_eff;
      if (sof && (mask_eff == '0) && (rx_drop_cnt != '1))
        rx_drop_cnt <= rx_drop_cnt + 32'd1;
    end else begin
      done <= done | (m_rx_tvalid & m_rx_tready);
    end
  end

  // ---------------- TX merge ----------------
  typedef enum logic {TX_IDLE, TX_LOCKED} tx_state_t;

  tx_state_t       tx_state, tx_state_nxt;
  logic [GW-1:0]   grant, grant_nxt;
  logic [GW-1:0]   last_grant, last_grant_nxt;
  logic [GW-1:0]   rr_pick;
  logic [SW-1:0]   pick_sum;
  logic [2*NP-1:0] rot_valid;
  logic            found;

  // Rotating a doubled valid vector puts port last_grant+1 at bit 0, so the
  // first set bit is the round-robin winner without modulo indexing.
  always_comb begin
    rot_valid = {s_tx_tvalid, s_tx_tvalid} >> (SW'(last_grant) + SW'(1));
    found     = 1'b0;
    pick_sum  = '0;
    for (int unsigned k = 0; k < NP; k++) begin
      if (!found && rot_valid[k]) begin
        found    = 1'b1;
        pick_sum = SW'(last_grant) + SW'(k) + SW'(1);
      end
    end
    rr_pick = (pick_sum >= SW'(NP)) ? GW'(pick_sum - SW'(NP)) : GW'(pick_sum);
  end

  always_comb begin
    tx_state_nxt   = tx_state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    m_tx_tdata     = '0;
    m_tx_tkeep     = '0;
    m_tx_tvalid    = 1'b0;
    m_tx_tlast     = 1'b0;
    m_tx_tuser     = '0;
    s_tx_tready    = '0;
    case (tx_state)
      TX_IDLE: begin
        if (|s_tx_tvalid) begin
          grant_nxt    = rr_pick;
          tx_state_nxt = TX_LOCKED;
        end
      end
      TX_LOCKED: begin
        for (int unsigned j = 0; j < NP; j++) begin
          if (GW'(j) == grant) begin
            m_tx_tdata     = s_tx_tdata[j*DATA_WIDTH +: DATA_WIDTH];
            m_tx_tkeep     = s_tx_tkeep[j*KEEP_WIDTH +: KEEP_WIDTH];
            m_tx_tuser     = s_tx_tuser[j*TX_USER_WIDTH +: TX_USER_WIDTH];
            m_tx_tlast     = s_tx_tlast[j];
            m_tx_tvalid    = s_tx_tvalid[j];
            s_tx_tready[j] = m_tx_tready;
          end
        end
        if (m_tx_tvalid && m_tx_tready && m_tx_tlast) begin
          last_grant_nxt = grant;
          tx_state_nxt   = TX_IDLE;
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state   <= TX_IDLE;
      grant      <= '0;
      last_grant <= GW'(NP - 1);
    end else begin
      tx_state   <= tx_state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
    end
  end

endmodule

// File: tb/tb_beehive_port_steer.sv
// Randomized bench for beehive_port_steer: frame/packet queues model the fork and the
// round-robin merge at transaction level.
module tb_beehive_port_steer;
  localparam int DW = 32;
  localparam int KW = 4;
  localparam int NA = 2;
  localparam int NP = NA + 1;
  localparam int BUDGET = 20000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [DW-1:0]    s_rx_tdata;
  logic [KW-1:0]    s_rx_tkeep;
  logic             s_rx_tvalid, s_rx_tlast, s_rx_tready;
  logic [0:0]       s_rx_tuser;
  logic [NP-1:0]    s_rx_dest_mask;
  logic [DW-1:0]    m_rx_tdata;
  logic [KW-1:0]    m_rx_tkeep;
  logic             m_rx_tlast;
  logic [0:0]       m_rx_tuser;
  logic [NP-1:0]    m_rx_tvalid, m_rx_tready;
  logic [NP*DW-1:0] s_tx_tdata;
  logic [NP*KW-1:0] s_tx_tkeep;
  logic [NP-1:0]    s_tx_tlast, s_tx_tuser, s_tx_tvalid, s_tx_tready;
  logic [DW-1:0]    m_tx_tdata;
  logic [KW-1:0]    m_tx_tkeep;
  logic             m_tx_tvalid, m_tx_tlast, m_tx_tready;
  logic [0:0]       m_tx_tuser;
  logic [31:0]      rx_drop_cnt;

  beehive_port_steer #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .RX_USER_WIDTH(1), .TX_USER_WIDTH(1), .NUM_APPS(NA)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_rx_tdata(s_rx_tdata), .s_rx_tkeep(s_rx_tkeep), .s_rx_tvalid(s_rx_tvalid),
    .s_rx_tlast(s_rx_tlast), .s_rx_tuser(s_rx_tuser), .s_rx_tready(s_rx_tready),
    .s_rx_dest_mask(s_rx_dest_mask),
    .m_rx_tdata(m_rx_tdata), .m_rx_tkeep(m_rx_tkeep), .m_rx_tlast(m_rx_tlast),
    .m_rx_tuser(m_rx_tuser), .m_rx_tvalid(m_rx_tvalid), .m_rx_tready(m_rx_tready),
    .s_tx_tdata(s_tx_tdata), .s_tx_tkeep(s_tx_tkeep), .s_tx_tlast(s_tx_tlast),
    .s_tx_tuser(s_tx_tuser), .s_tx_tvalid(s_tx_tvalid), .s_tx_tready(s_tx_tready),
    .m_tx_tdata(m_tx_tdata), .m_tx_tkeep(m_tx_tkeep), .m_tx_tvalid(m_tx_tvalid),
    .m_tx_tlast(m_tx_tlast), .m_tx_tuser(m_tx_tuser), .m_tx_tready(m_tx_tready),
    .rx_drop_cnt(rx_drop_cnt)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic          u;
    logic [NP-1:0] m;   // value driven on s_rx_dest_mask with this beat
    logic [NP-1:0] fm;  // destinations of the frame (first-beat mask)
  } beat_t;

  beat_t rxq[$];
  beat_t txq[NP][$];

  int total = 0;
  int bad   = 0;
  int exp_drops, frames_left, seq;
  int pkts_left[NP];
  int cur, last_src;
  bit rx_held, rx_mid, in_pkt;
  logic [NP-1:0] got;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic push_frame();
    int len;
    logic [NP-1:0] fm;
    beat_t b;
    len = int'($urandom_range(1, 4));
    fm  = NP'($urandom_range(0, 7));
    if (fm == '0) exp_drops++;
    for (int i = 0; i < len; i++) begin
      b.d  = $urandom;
      b.k  = KW'($urandom);
      b.u  = 1'($urandom);
      b.l  = (i == len - 1);
      b.fm = fm;
      b.m  = (i == 0) ? fm : NP'($urandom);
      rxq.push_back(b);
    end
  endtask

  task automatic push_pkt(input int s);
    int len;
    beat_t b;
    len = int'($urandom_range(1, 4));
    for (int i = 0; i < len; i++) begin
      b.d  = {8'(s), 8'(seq), 16'(i)};
      b.k  = KW'($urandom);
      b.u  = 1'($urandom);
      b.l  = (i == len - 1);
      b.m  = '0;
      b.fm = '0;
      txq[s].push_back(b);
    end
    seq++;
  endtask

  task automatic drive();
    if (!rx_held) begin
      if (rxq.size() == 0 && frames_left > 0) begin
        push_frame();
        frames_left--;
      end
      s_rx_tvalid = (rxq.size() != 0) && ($urandom_range(0, 3) != 0);
    end
    if (rxq.size() != 0) begin
      s_rx_tdata     = rxq[0].d;
      s_rx_tkeep     = rxq[0].k;
      s_rx_tlast     = rxq[0].l;
      s_rx_tuser     = rxq[0].u;
      s_rx_dest_mask = rxq[0].m;
    end
    m_rx_tready = NP'($urandom) | NP'($urandom);
    for (int s = 0; s < NP; s++) begin
      if (txq[s].size() == 0 && pkts_left[s] > 0 && $urandom_range(0, 2) == 0) begin
        push_pkt(s);
        pkts_left[s]--;
      end
      s_tx_tvalid[s] = (txq[s].size() != 0);
      if (txq[s].size() != 0) begin
        s_tx_tdata[s*DW +: DW] = txq[s][0].d;
        s_tx_tkeep[s*KW +: KW] = txq[s][0].k;
        s_tx_tlast[s]          = txq[s][0].l;
        s_tx_tuser[s]          = txq[s][0].u;
      end
    end
    m_tx_tready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic monitor();
    logic [NP-1:0] hsv;
    bit found;
    if (s_rx_tvalid) begin
      check_eq("rx_valid", 64'(m_rx_tvalid), 64'(rxq[0].fm & ~got));
      check_eq("rx_ready", 64'(s_rx_tready), 64'(&(~rxq[0].fm | got | m_rx_tready)));
      hsv = m_rx_tvalid & m_rx_tready;
      if (hsv != '0)
        check_eq("rx_beat", 64'({m_rx_tdata, m_rx_tkeep, m_rx_tlast, m_rx_tuser}),
                 64'({rxq[0].d, rxq[0].k, rxq[0].l, rxq[0].u}));
      got = got | hsv;
      if (s_rx_tready) begin
        rx_mid = !rxq[0].l;
        void'(rxq.pop_front());
        got     = '0;
        rx_held = 1'b0;
      end else begin
        rx_held = 1'b1;
      end
    end else begin
      check_eq("rx_idle_valid", 64'(m_rx_tvalid), 64'(0));
      rx_held = 1'b0;
    end

    if (in_pkt) begin
      check_eq("tx_valid", 64'(m_tx_tvalid), 64'(1));
      check_eq("tx_src_ready", 64'(s_tx_tready), 64'(NP'(m_tx_tready) << cur));
      if (m_tx_tvalid && m_tx_tready) begin
        check_eq("tx_beat", 64'({m_tx_tdata, m_tx_tkeep, m_tx_tlast, m_tx_tuser}),
                 64'({txq[cur][0].d, txq[cur][0].k, txq[cur][0].l, txq[cur][0].u}));
        if (txq[cur][0].l) begin
          in_pkt   = 1'b0;
          last_src = cur;
        end
        void'(txq[cur].pop_front());
      end
    end else begin
      check_eq("tx_bubble", 64'({m_tx_tvalid, s_tx_tready}), 64'(0));
      found = 1'b0;
      for (int k = 1; k <= NP; k++) begin
        if (!found && s_tx_tvalid[(last_src + k) % NP]) begin
          found  = 1'b1;
          cur    = (last_src + k) % NP;
          in_pkt = 1'b1;
        end
      end
    end
  endtask

  task automatic run_phase(input int nf, input int npk, input bit abort, input int abort_at);
    bit timed_out;
    bit idle_all;
    rxq.delete();
    for (int s = 0; s < NP; s++) begin
      txq[s].delete();
      pkts_left[s] = npk;
    end
    frames_left = nf;
    exp_drops   = 0;
    rx_held     = 1'b0;
    rx_mid      = 1'b0;
    in_pkt      = 1'b0;
    got         = '0;
    cur         = 0;
    last_src    = NP - 1;
    timed_out   = 1'b0;
    for (int cyc = 0; ; cyc++) begin
      @(posedge clk); #1;
      drive();
      @(negedge clk);
      monitor();
      idle_all = (frames_left == 0) && (rxq.size() == 0) && !in_pkt;
      for (int s = 0; s < NP; s++)
        if (pkts_left[s] != 0 || txq[s].size() != 0) idle_all = 1'b0;
      if (abort) begin
        if ((cyc >= abort_at && rx_mid && in_pkt) || cyc >= abort_at + 400) break;
      end else if (idle_all) begin
        break;
      end else if (cyc >= BUDGET) begin
        timed_out = 1'b1;
        break;
      end
    end
    if (!abort) begin
      check_eq("phase_timeout", 64'(timed_out), 64'(0));
      @(posedge clk); #1;
      s_rx_tvalid = 1'b0;
      s_tx_tvalid = '0;
      check_eq("drop_cnt", 64'(rx_drop_cnt), 64'(exp_drops));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_m_rx_tvalid"}, 64'(m_rx_tvalid), 64'(0));
    check_eq({tag, "_s_rx_tready"}, 64'(s_rx_tready), 64'(0));
    check_eq({tag, "_m_tx_tvalid"}, 64'(m_tx_tvalid), 64'(0));
    check_eq({tag, "_s_tx_tready"}, 64'(s_tx_tready), 64'(0));
    check_eq({tag, "_drop_cnt"}, 64'(rx_drop_cnt), 64'(0));
  endtask

  initial begin
    rst_n          = 1'b0;
    s_rx_tdata     = '0;
    s_rx_tkeep     = '0;
    s_rx_tvalid    = 1'b0;
    s_rx_tlast     = 1'b0;
    s_rx_tuser     = '0;
    s_rx_dest_mask = '0;
    m_rx_tready    = '0;
    s_tx_tdata     = '0;
    s_tx_tkeep     = '0;
    s_tx_tlast     = '0;
    s_tx_tuser     = '0;
    s_tx_tvalid    = '0;
    m_tx_tready    = 1'b0;
    seq            = 0;
    #1;
    check_reset_outputs("rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_phase(80, 20, 1'b0, 0);

    // Interrupt a run mid-frame with a one-cycle reset, then start clean.
    run_phase(40, 10, 1'b1, 30);
    #2;
    rst_n          = 1'b0;
    s_rx_tvalid    = 1'b1;
    s_rx_dest_mask = '1;
    m_rx_tready    = '1;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    check_reset_outputs("midrst_hold");
    s_rx_tvalid = 1'b0;
    s_tx_tvalid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    run_phase(30, 8, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
